inv_share_arb: RTL and testbench

- Shares one external 3-bit inverter datapath (combinational, dout = ~din) between NREQ requesters.
- Each requester presents a valid/ready request carrying an operand. The block round-robin arbitrates, drives the operand onto the shared inverter, captures the result and returns it with the winner's ID over a valid/ready response channel.
- Self-checks every result against the bitwise complement of the operand and flags mismatches.
- Sits between the stimulus masters and the shared inverter instance.

---
 rtl/inv_share_arb.sv | 141 ++++++++++++++
 tb/tb_inv_share_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_share_arb.sv
// Round-robin arbiter that shares one external inverter datapath between NREQ
// requesters, returns each result with its owner ID and self-checks the result.
module inv_share_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 3,
   parameter int unsigned IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [W-1:0]      inv_din,
   input  logic [W-1:0]      inv_dout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic              err,
   output logic [7:0]        err_cnt
);

   localparam int unsigned CNTW = 8;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] last;
   logic [IDW-1:0] gid;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] g_hi;
   logic [IDW-1:0] g_lo;
   logic           any_hi;
   logic           any_lo;
   logic           any_req;
   logic [W-1:0]   grant_data;
   logic           mismatch;

   // Round-robin pick: lowest requester above last, else lowest overall.
   always_comb begin
      g_hi       = '0;
      g_lo       = '0;
      any_hi     = 1'b0;
      any_lo     = 1'b0;
      grant_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_valid[i] && !any_lo) begin
            g_lo   = IDW'(i);
            any_lo = 1'b1;
         end
         if (req_valid[i] && (IDW'(i) > last) && !any_hi) begin
            g_hi   = IDW'(i);
            any_hi = 1'b1;
         end
      end
      grant   = any_hi ? g_hi : g_lo;
      any_req = any_lo;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (IDW'(i) == grant) begin
            grant_data = req_data[i*W +: W];
         end
      end
   end

   assign mismatch = (inv_dout != ~inv_din);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (any_req && !rst) begin
               state_nxt = ISSUE;
               for (int unsigned i = 0; i < NREQ; i++) begin
                  req_ready[i] = (IDW'(i) == grant);
               end
            end
         end
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and response registers; inv_din only moves on an accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= IDW'(NREQ - 1);
         gid       <= '0;
         inv_din   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  inv_din <= grant_data;
                  gid     <= grant;
                  last    <= grant;
               end
            end
            CAPTURE: begin
               rsp_data  <= inv_dout;
               rsp_id    <= gid;
               rsp_valid <= 1'b1;
               if (mismatch) begin
                  err <= 1'b1;
                  if (err_cnt != CNT_MAX) begin
                     err_cnt <= err_cnt + 8'd1;
                  end
               end
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_share_arb.sv
// Scoreboard bench for inv_share_arb: per-requester operand queues, a round-robin
// reference model for grants, and expected responses checked at the handshake.
module tb_inv_share_arb;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 3;
   localparam int unsigned IDW  = 2;

   typedef struct {
      int         id;
      logic [2:0] data;
      bit         fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [11:0] req_data;
   logic [3:0]  req_ready;
   logic [2:0]  inv_din;
   logic [2:0]  inv_dout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [2:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        err;
   logic [7:0]  err_cnt;

   logic        fault_en;
   logic        bp_mode;

   logic [2:0]  op_q[4][$];
   exp_t        sb[$];
   int          grants[$];

   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   // External shared inverter; fault_en makes it a pass-through.
   assign inv_dout = fault_en ? inv_din : ~inv_din;

   inv_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .inv_din   (inv_din),
      .inv_dout  (inv_dout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int lst);
      for (int k = 1; k <= 4; k++) begin
         if (v[(lst + k) % 4]) return (lst + k) % 4;
      end
      return -1;
   endfunction

   // Requester and consumer drivers, updated just after each rising edge.
   int hold_cnt = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            req_valid[i] = (op_q[i].size() != 0);
            req_data[i*3 +: 3] = (op_q[i].size() != 0) ? op_q[i][0] : 3'd0;
         end
         if (rsp_valid) hold_cnt++;
         else hold_cnt = 0;
         rsp_ready = !bp_mode || (hold_cnt > 5);
      end
   end

   // Monitor at the falling edge: grant model, scoreboard, stability, latency.
   int         cyc = 0;
   int         acc_cyc = 0;
   int         last_m = 3;
   int         exp_g;
   logic [3:0] exp_rdy;
   logic [2:0] exp_din = 3'd0;
   logic [2:0] acc_op = 3'd0;
   bit         acc_prev = 0;
   bit         rv_prev = 0;
   bit         post_rst = 0;
   bit         exp_err = 0;
   int         exp_cnt = 0;
   logic [2:0] prev_data = 3'd0;
   logic [1:0] prev_id = 2'd0;
   exp_t       e;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("ready_in_rst", 32'(req_ready), 32'd0);
         sb.delete();
         last_m   = 3;
         exp_din  = 3'd0;
         exp_err  = 0;
         exp_cnt  = 0;
         rv_prev  = 0;
         acc_prev = 0;
         post_rst = 1;
      end else begin
         if (post_rst) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_err_cnt", 32'(err_cnt), 32'd0);
            post_rst = 0;
         end
         exp_g = (sb.size() == 0) ? rr_pick(req_valid, last_m) : -1;
         exp_rdy = (exp_g >= 0) ? (4'b0001 << exp_g) : 4'b0000;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (acc_prev) exp_din = acc_op;
         chk("inv_din", 32'(inv_din), 32'(exp_din));
         acc_prev = 0;
         if (exp_g >= 0 && req_ready[exp_g] && op_q[exp_g].size() != 0) begin
            acc_op  = op_q[exp_g].pop_front();
            e.id    = exp_g;
            e.fault = fault_en;
            e.data  = fault_en ? acc_op : ~acc_op;
            sb.push_back(e);
            acc_prev = 1;
            acc_cyc  = cyc;
            last_m   = exp_g;
            grants.push_back(exp_g);
         end
         if (rsp_valid && !rv_prev) chk("latency", 32'(cyc - acc_cyc), 32'd3);
         if (rsp_valid && rv_prev) begin
            chk("hold_data", 32'(rsp_data), 32'(prev_data));
            chk("hold_id", 32'(rsp_id), 32'(prev_id));
         end
         if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               if (e.fault) begin
                  exp_err = 1;
                  if (exp_cnt < 255) exp_cnt++;
               end
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
               chk("err", 32'(err), 32'(exp_err));
               chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
            end
         end
         rv_prev   = rsp_valid;
         prev_data = rsp_data;
         prev_id   = rsp_id;
      end
   end

   task automatic wait_idle(input int budget);
      int  n = 0;
      bit  idle = 0;
      while (!idle && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         idle = (sb.size() == 0) && !rsp_valid && (op_q[0].size() == 0) &&
                (op_q[1].size() == 0) && (op_q[2].size() == 0) && (op_q[3].size() == 0);
      end
      chk("idle_timeout", 32'(idle), 32'd1);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
      fault_en = 1'b0; bp_mode = 1'b0;
      step(); step();
      rst = 1'b0;

      // All four requesters continuously valid from reset.
      grants.delete();
      step();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++) op_q[i].push_back(3'(i + 1));
      wait_idle(200);
      chk("rr_count", 32'(grants.size()), 32'd8);
      for (int k = 0; k < grants.size() && k < 8; k++) chk("rr_order", 32'(grants[k]), 32'(k % 4));

      // Single requester.
      step();
      op_q[0].push_back(3'b010);
      wait_idle(50);

      // Operand sweep on requester 2.
      step();
      for (int v = 0; v < 8; v++) op_q[2].push_back(3'(v));
      wait_idle(200);

      // Backpressure with everyone requesting.
      bp_mode = 1'b1;
      step();
      for (int i = 0; i < 4; i++) op_q[i].push_back(3'($urandom_range(7)));
      wait_idle(300);
      bp_mode = 1'b0;

      // Fault injection.
      fault_en = 1'b1;
      step();
      for (int k = 0; k < 3; k++) op_q[3].push_back(3'(k + 3));
      wait_idle(100);
      chk("fault_err", 32'(err), 32'd1);
      chk("fault_cnt3", 32'(err_cnt), 32'd3);
      fault_en = 1'b0;
      step();
      op_q[1].push_back(3'd5);
      wait_idle(50);
      chk("clean_err", 32'(err), 32'd1);
      chk("clean_cnt", 32'(err_cnt), 32'd3);
      fault_en = 1'b1;
      step();
      for (int k = 0; k < 300; k++) op_q[1].push_back(3'($urandom_range(7)));
      wait_idle(2000);
      chk("sat_cnt", 32'(err_cnt), 32'd255);
      fault_en = 1'b0;

      // Reset while a requester-0 transaction sits in ISSUE.
      step();
      op_q[0].push_back(3'd5);
      begin
         int n = 0;
         while (sb.size() == 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk("rst_accept_seen", 32'(sb.size() != 0), 32'd1);
      end
      step();
      rst = 1'b1;
      op_q[0].push_back(3'd6);
      op_q[1].push_back(3'd7);
      step();
      rst = 1'b0;
      grants.delete();
      wait_idle(100);
      chk("rst_grants", 32'(grants.size()), 32'd2);
      if (grants.size() == 2) begin
         chk("rst_first_grant", 32'(grants[0]), 32'd0);
         chk("rst_second_grant", 32'(grants[1]), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule
